// File: rtl/nybble_pkg.sv
// nybble_pkg: widths, opcode set and fetch-queue entry type shared by the
// nybble Forth core and its instruction prefetch stage.
package nybble_pkg;

    localparam int ADDR_W     = 16;
    localparam int MEM_ADDR_W = 12;
    localparam int BYTE_W     = 8;

    // Core opcode set; the prefetch stage passes these through untouched.
    typedef enum logic [3:0] {
        OP_NOOP    = 4'd0,
        OP_CALL    = 4'd1,
        OP_EXIT    = 4'd2,
        OP_ZBRANCH = 4'd3,
        OP_STORE   = 4'd4,
        OP_FETCH   = 4'd5,
        OP_CSTORE  = 4'd6,
        OP_CFETCH  = 4'd7,
        OP_LIT     = 4'd8,
        OP_ADD     = 4'd9,
        OP_NAND    = 4'd10,
        OP_TOR     = 4'd11,
        OP_RFROM   = 4'd12
    } opcode_e;

    // One queued program byte together with the address it was read from.
    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/nybble_fetch_fifo.sv
// nybble_fetch_fifo: synchronous FIFO of fetch_entry_t with occupancy output
// and a single-cycle clear used to flush the queue on a redirect.
module nybble_fetch_fifo
    import nybble_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                push_i,
    input  fetch_entry_t        push_entry_i,
    input  logic                pop_i,
    output fetch_entry_t        head_o,
    output logic [CNT_W-1:0]    count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Next-state pointers and occupancy; clear wins over push and pop.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != FULL) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)
                count_d = count_q + 1'b1;
            else if (!do_push && do_pop)
                count_d = count_q - 1'b1;
        end
    end

    // Control state: pointers and occupancy, reset to empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; only occupied slots are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i)
            mem_q[wr_ptr_q] <= push_entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/nybble_fetch.sv
// nybble_fetch: instruction-byte prefetch for the nybble Forth core.
// Issues sequential reads to the 4 KiB synchronous byte memory, tracks the
// single in-flight read, queues returned bytes and restarts on redirect.
// Optional macro NYBBLE_FETCH_TRACE_EN enables a simulation-only trace of
// delivered bytes and redirects; behaviour is otherwise identical.
module nybble_fetch
    import nybble_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  redirect,
    input  logic [ADDR_W-1:0]     redirect_pc,
    output logic                  mem_rd_en,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [BYTE_W-1:0]     mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BYTE_W-1:0]     out_byte,
    output logic [ADDR_W-1:0]     out_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic              push, pop;
    fetch_entry_t      push_entry, head;

    // Issue only when the queue has room for every byte already requested.
    always_comb begin
        occupancy       = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
        mem_rd_en       = !reset && !redirect && (occupancy < DEPTH_OCC);
        mem_addr        = fetch_pc_q[MEM_ADDR_W-1:0];
        out_valid       = (count != '0);
        pop             = out_valid && out_ready;
        push            = inflight_q && !redirect && !reset;
        push_entry.data = mem_rdata;
        push_entry.pc   = inflight_pc_q;
        out_byte        = head.data;
        out_pc          = head.pc;
        inflight_d      = mem_rd_en;
        fetch_pc_d      = fetch_pc_q;
        if (redirect)
            fetch_pc_d = redirect_pc;
        else if (mem_rd_en)
            fetch_pc_d = fetch_pc_q + 1'b1;
    end

    // Fetch address and in-flight flag; redirect drops any returning byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
        end
    end

    // Address tag of the outstanding read, paired with its data on return.
    always_ff @(posedge clock) begin
        if (mem_rd_en)
            inflight_pc_q <= fetch_pc_q;
    end

    nybble_fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i        (clock),
        .rst_i        (reset),
        .clear_i      (redirect),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count)
    );

`ifdef NYBBLE_FETCH_TRACE_EN
    // Simulation trace of every delivered byte and every redirect.
    always @(posedge clock) begin
        if (!reset && pop)
            $write("F %04x %02x ", out_pc, out_byte);
        if (!reset && redirect)
            $display("REDIRECT %04x", redirect_pc);
    end
`endif

endmodule

// File: tb/tb_nybble_fetch.sv
// tb_nybble_fetch: directed and randomized checks of nybble_fetch against a
// stream model: after reset or redirect to T, the core must see exactly the
// bytes mem[T], mem[T+1], ... with matching 16-bit addresses, in order.
module tb_nybble_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        mem_rd_en;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic [15:0] out_pc;

    logic [7:0]  mem [4096];

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_pc;
    int          hs_cnt = 0;
    logic [15:0] last_hs_pc;

    always #5 clock = ~clock;

    nybble_fetch #(
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_byte    (out_byte),
        .out_pc      (out_pc)
    );

    // Synchronous-read program memory.
    always @(posedge clock) begin
        if (mem_rd_en)
            mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Stream model, evaluated mid-cycle with inputs and outputs stable.
    task automatic sb();
        if (reset) begin
            exp_pc = 16'h0000;
        end else begin
            if (out_valid) begin
                chk("stream_pc", {16'h0, out_pc}, {16'h0, exp_pc});
                chk("stream_byte", {24'h0, out_byte}, {24'h0, mem[exp_pc[11:0]]});
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                last_hs_pc = out_pc;
                exp_pc = exp_pc + 16'd1;
            end
            if (redirect)
                exp_pc = redirect_pc;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        sb();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int   hs_before;
        logic found;

        for (int i = 0; i < 4096; i++)
            mem[i] = 8'($urandom);
        mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h40; mem[4] = 8'h50;

        reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; out_ready = 1'b1;
        exp_pc = 16'h0;
        tick(); tick(); tick();
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_valid", out_valid, 0);

        // Reset release: first byte two edges later, then one byte per cycle.
        reset = 1'b0; #1;
        chk("rel_rd_en", mem_rd_en, 1);
        chk("rel_addr", mem_addr, 12'h000);
        chk("rel_valid0", out_valid, 0);
        tick();
        chk("rel_valid1", out_valid, 0);
        chk("rel_addr1", mem_addr, 12'h001);
        tick();
        chk("first_valid", out_valid, 1);
        chk("first_pc", out_pc, 16'h0000);
        chk("first_byte", out_byte, 8'h10);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stream_rate", out_valid, 1);
        end

        // Hold ready low from reset: queue fills, reads stop, then drains in order.
        reset = 1'b1; out_ready = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("full_rd_en", mem_rd_en, 0);
        chk("full_head", out_pc, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_hold_rd_en", mem_rd_en, 0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("drain_rate", out_valid, 1);
        end
        out_ready = 1'b0;
        tick();

        // Redirect with a full queue and a read in flight.
        redirect = 1'b1; redirect_pc = 16'h0123; #1;
        chk("redir_no_issue", mem_rd_en, 0);
        tick();
        redirect = 1'b0; #1;
        chk("redir_flush", out_valid, 0);
        chk("redir_rd_en", mem_rd_en, 1);
        chk("redir_addr", mem_addr, 12'h123);
        tick();
        chk("redir_valid1", out_valid, 0);
        tick();
        out_ready = 1'b1; #1;
        chk("redir_valid2", out_valid, 1);
        chk("redir_pc", out_pc, 16'h0123);
        chk("redir_byte", out_byte, mem[12'h123]);

        // Redirect in the same cycle as the handshake of pc 0x0007.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (out_valid && out_pc == 16'h0007) found = 1'b1;
            else tick();
        end
        chk("find_pc7", found, 1);
        hs_before = hs_cnt;
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        chk("hs_with_redir", hs_cnt, hs_before + 1);
        chk("hs_with_redir_pc", last_hs_pc, 16'h0007);
        redirect = 1'b0;
        tick(); tick();
        chk("after_hs_redir_valid", out_valid, 1);
        chk("after_hs_redir_pc", out_pc, 16'h0040);

        // Address wrap at the top of the 16-bit space.
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0; #1;
        chk("wrap_addr0", mem_addr, 12'hFFE);
        tick();
        chk("wrap_addr1", mem_addr, 12'hFFF);
        tick();
        chk("wrap_addr2", mem_addr, 12'h000);
        chk("wrap_pc0", out_pc, 16'hFFFE);
        tick();
        chk("wrap_pc1", out_pc, 16'hFFFF);
        tick();
        chk("wrap_pc2", out_pc, 16'h0000);
        chk("wrap_byte2", out_byte, 8'h10);

        // One-cycle reset mid-stream with the queue full.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("pre_rst_full", out_valid, 1);
        reset = 1'b1; #1;
        chk("midrst_rd_en", mem_rd_en, 0);
        tick();
        reset = 1'b0; #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_restart", mem_rd_en, 1);
        chk("midrst_addr", mem_addr, 12'h000);
        out_ready = 1'b1;
        tick(); tick();
        chk("midrst_first_valid", out_valid, 1);
        chk("midrst_first_pc", out_pc, 16'h0000);

        // Randomized back-pressure and redirects against the stream model.
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect    = 1'b1;
                redirect_pc = 16'($urandom);
            end else begin
                redirect = 1'b0;
            end
            tick();
        end
        redirect = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        chk("rand_end_valid", out_valid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
